// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : cache-side and memory-side bus bundle for mem_arbiter.
// Rev 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16
);
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_req_data_valid;
  logic              dc_req_data_ready;
  logic [DATA_W-1:0] dc_req_data;
  logic [MASK_W-1:0] dc_req_mask;
  logic              dc_resp_valid;

  logic [DATA_W-1:0] resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_data_valid;
  logic              mem_req_data_ready;
  logic [DATA_W-1:0] mem_req_data_bits;
  logic [MASK_W-1:0] mem_req_data_mask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  // Arbiter view
  modport slave (
    input  ic_req_valid, ic_req_addr,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data_valid, dc_req_data, dc_req_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
    output ic_req_ready, ic_resp_valid, dc_req_ready, dc_req_data_ready, dc_resp_valid,
    output resp_data, mem_req_valid, mem_req_rw, mem_req_addr,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
  );

  // Environment view (caches plus memory model)
  modport master (
    output ic_req_valid, ic_req_addr,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data_valid, dc_req_data, dc_req_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data,
    input  ic_req_ready, ic_resp_valid, dc_req_ready, dc_req_data_ready, dc_resp_valid,
    input  resp_data, mem_req_valid, mem_req_rw, mem_req_addr,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory port between ICache and DCache; steers refill
//               beats to the granted cache. Define MEM_ARB_RR_EN for round-robin
//               arbitration on simultaneous requests (default: DCache priority).
// Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int BEATS  = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  mem_arbiter_if.slave bus,
  output logic         busy_o,
  output logic         proto_err_o
);
  localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic             OWN_IC    = 1'b0;
  localparam logic             OWN_DC    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             proto_err_q;
  logic             grant_dc;
  logic             own_valid;
  logic             own_rw;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;
  assign grant_dc = (bus.ic_req_valid && bus.dc_req_valid) ? ~last_owner_q : bus.dc_req_valid;
`else
  assign grant_dc = bus.dc_req_valid;
`endif

  assign own_valid   = (owner_q == OWN_DC) ? bus.dc_req_valid : bus.ic_req_valid;
  assign own_rw      = (owner_q == OWN_DC) && bus.dc_req_rw;
  assign busy_o      = (state_q != S_IDLE);
  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_DC;
      beat_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_DC;
`endif
    end else begin
      // Beats outside a refill are discarded; flag remains until reset.
      if (bus.mem_resp_valid && (state_q != S_RDATA)) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.ic_req_valid || bus.dc_req_valid) begin
            owner_q      <= grant_dc;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= grant_dc;
`endif
            state_q      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!own_valid) begin
            state_q <= S_IDLE;
          end else if (bus.mem_req_ready) begin
            state_q    <= own_rw ? S_WDATA : S_RDATA;
            beat_cnt_q <= '0;
          end
        end
        S_WDATA: begin
          if (bus.dc_req_data_valid && bus.mem_req_data_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (bus.mem_resp_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
              state_q    <= S_IDLE;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshakes pass straight through, gated by the registered state and owner.
  always_comb begin
    bus.ic_req_ready       = 1'b0;
    bus.dc_req_ready       = 1'b0;
    bus.dc_req_data_ready  = 1'b0;
    bus.ic_resp_valid      = 1'b0;
    bus.dc_resp_valid      = 1'b0;
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_rw         = 1'b0;
    bus.mem_req_addr       = {ADDR_W{1'b0}};
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_data_bits  = {DATA_W{1'b0}};
    bus.mem_req_data_mask  = {MASK_W{1'b0}};
    bus.resp_data          = bus.mem_resp_data;
    case (state_q)
      S_ADDR: begin
        bus.mem_req_valid = own_valid;
        bus.mem_req_rw    = own_rw;
        if (owner_q == OWN_DC) begin
          bus.mem_req_addr      = bus.dc_req_addr;
          bus.mem_req_data_bits = bus.dc_req_data;
          bus.mem_req_data_mask = bus.dc_req_mask;
          bus.dc_req_ready      = bus.mem_req_ready;
        end else begin
          bus.mem_req_addr = bus.ic_req_addr;
          bus.ic_req_ready = bus.mem_req_ready;
        end
      end
      S_WDATA: begin
        bus.mem_req_data_valid = bus.dc_req_data_valid;
        bus.dc_req_data_ready  = bus.mem_req_data_ready;
        bus.mem_req_data_bits  = bus.dc_req_data;
        bus.mem_req_data_mask  = bus.dc_req_mask;
      end
      S_RDATA: begin
        if (owner_q == OWN_DC) begin
          bus.dc_resp_valid = bus.mem_resp_valid;
        end else begin
          bus.ic_resp_valid = bus.mem_resp_valid;
        end
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire
